vram_writer: RTL and testbench

VRAM_WRITER -- requirements
Module: vram_writer

---
 rtl/vram_writer_pkg.sv | 39 +++
 rtl/rect_scan.sv | 58 +++++
 rtl/vram_writer.sv | 145 ++++++++++++++
 tb/tb_vram_writer.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/vram_writer_pkg.sv
// rtl/vram_writer_pkg.sv - shared video package: resolution defaults, writer states, RGB444->RGB332 packing
package vram_writer_pkg;

  localparam int unsigned H_RES_DEF = 640;
  localparam int unsigned V_RES_DEF = 480;

  localparam int COL_W   = 10;
  localparam int ROW_W   = 9;
  localparam int COLOR_W = 12;

  // Field positions inside the packed {b[3:0], g[3:0], r[3:0]} colour word
  localparam int R_MSB = 3;
  localparam int R_LSB = 1;
  localparam int G_MSB = 7;
  localparam int G_LSB = 5;
  localparam int B_MSB = 11;
  localparam int B_LSB = 10;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FILL   = 2'd1,
    ST_FINISH = 2'd2
  } wr_state_e;

  typedef struct packed {
    logic [2:0] r;
    logic [2:0] g;
    logic [1:0] b;
  } rgb332_t;

  function automatic rgb332_t rgb444_to_332(input logic [COLOR_W-1:0] c);
    rgb332_t p;
    p.r = c[R_MSB:R_LSB];
    p.g = c[G_MSB:G_LSB];
    p.b = c[B_MSB:B_LSB];
    return p;
  endfunction

endpackage

// File: rtl/rect_scan.sv
// rtl/rect_scan.sv - raster x/y counter over an inclusive rectangle with next-position and last flag
module rect_scan
  import vram_writer_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_load,
  input  logic [COL_W-1:0] i_x0,
  input  logic [COL_W-1:0] i_x1,
  input  logic [ROW_W-1:0] i_y0,
  input  logic [ROW_W-1:0] i_y1,
  input  logic             i_step,
  output logic [COL_W-1:0] o_nx,
  output logic [ROW_W-1:0] o_ny,
  output logic             o_last
);

  logic [COL_W-1:0] r_x0;
  logic [COL_W-1:0] r_x1;
  logic [ROW_W-1:0] r_y1;
  logic [COL_W-1:0] r_x;
  logic [ROW_W-1:0] r_y;

  logic             w_row_end;
  logic             w_last;
  logic [COL_W-1:0] w_nx;
  logic [ROW_W-1:0] w_ny;

  assign w_row_end = (r_x == r_x1);
  assign w_last    = w_row_end && (r_y == r_y1);
  // The increments below are only consumed when not last, so x stays <= x1 and y <= y1
  assign w_nx      = w_row_end ? r_x0 : (r_x + 10'd1);
  assign w_ny      = w_row_end ? (r_y + 9'd1) : r_y;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_x0 <= '0;
      r_x1 <= '0;
      r_y1 <= '0;
      r_x  <= '0;
      r_y  <= '0;
    end else if (i_load) begin
      r_x0 <= i_x0;
      r_x1 <= i_x1;
      r_y1 <= i_y1;
      r_x  <= i_x0;
      r_y  <= i_y0;
    end else if (i_step && !w_last) begin
      r_x  <= w_nx;
      r_y  <= w_ny;
    end
  end

  assign o_nx   = w_nx;
  assign o_ny   = w_ny;
  assign o_last = w_last;

endmodule

// File: rtl/vram_writer.sv
// rtl/vram_writer.sv - rectangle fill engine writing RGB332 pixels into VRAM one per clock
module vram_writer
  import vram_writer_pkg::*;
#(
  parameter int H_RES = H_RES_DEF,
  parameter int V_RES = V_RES_DEF
) (
  input  logic               vga_clk,
  input  logic               rst_n,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [COL_W-1:0]   cmd_x0,
  input  logic [COL_W-1:0]   cmd_x1,
  input  logic [ROW_W-1:0]   cmd_y0,
  input  logic [ROW_W-1:0]   cmd_y1,
  input  logic [COLOR_W-1:0] cmd_color,
  input  logic               abort,
  output logic               wr_en,
  output logic [ROW_W-1:0]   wr_row,
  output logic [COL_W-1:0]   wr_col,
  output logic [2:0]         wr_r,
  output logic [2:0]         wr_g,
  output logic [1:0]         wr_b,
  output logic               busy,
  output logic               done
);

  localparam logic [COL_W-1:0] X_MAX = COL_W'(H_RES - 1);
  localparam logic [ROW_W-1:0] Y_MAX = ROW_W'(V_RES - 1);
  localparam logic [COL_W:0]   X_LIM = (COL_W + 1)'(H_RES);
  localparam logic [ROW_W:0]   Y_LIM = (ROW_W + 1)'(V_RES);

  wr_state_e        r_state;
  logic             r_ready;
  logic             r_wr_en;
  logic [ROW_W-1:0] r_row;
  logic [COL_W-1:0] r_col;
  rgb332_t          r_rgb;
  logic             r_busy;
  logic             r_done;

  logic             w_accept;
  logic [COL_W-1:0] w_x1c;
  logic [ROW_W-1:0] w_y1c;
  logic             w_empty;
  rgb332_t          w_rgb;
  logic [COL_W-1:0] w_nx;
  logic [ROW_W-1:0] w_ny;
  logic             w_last;
  logic             w_step;

  assign w_accept = cmd_valid && r_ready;
  assign w_x1c    = (cmd_x1 > X_MAX) ? X_MAX : cmd_x1;
  assign w_y1c    = (cmd_y1 > Y_MAX) ? Y_MAX : cmd_y1;
  assign w_empty  = (cmd_x0 > w_x1c) || (cmd_y0 > w_y1c) ||
                    ({1'b0, cmd_x0} >= X_LIM) || ({1'b0, cmd_y0} >= Y_LIM);
  assign w_rgb    = rgb444_to_332(cmd_color);
  assign w_step   = (r_state == ST_FILL) && !abort;

  // The scanner tracks the pixel currently on the write port; its next position feeds the registers
  rect_scan u_scan (
    .i_clk   (vga_clk),
    .i_rst_n (rst_n),
    .i_load  (w_accept && !w_empty),
    .i_x0    (cmd_x0),
    .i_x1    (w_x1c),
    .i_y0    (cmd_y0),
    .i_y1    (w_y1c),
    .i_step  (w_step),
    .o_nx    (w_nx),
    .o_ny    (w_ny),
    .o_last  (w_last)
  );

  always_ff @(posedge vga_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_ready <= 1'b0;
      r_wr_en <= 1'b0;
      r_row   <= '0;
      r_col   <= '0;
      r_rgb   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_done <= 1'b0;
          if (w_accept) begin
            r_ready <= 1'b0;
            r_busy  <= 1'b1;
            if (w_empty) begin
              r_state <= ST_FINISH;
              r_done  <= 1'b1;
            end else begin
              r_state <= ST_FILL;
              r_wr_en <= 1'b1;
              r_row   <= cmd_y0;
              r_col   <= cmd_x0;
              r_rgb   <= w_rgb;
            end
          end else begin
            r_ready <= 1'b1;
          end
        end
        ST_FILL: begin
          // Abort is checked first so it wins over the final-pixel transition
          if (abort || w_last) begin
            r_state <= ST_FINISH;
            r_wr_en <= 1'b0;
            r_done  <= 1'b1;
          end else begin
            r_wr_en <= 1'b1;
            r_row   <= w_ny;
            r_col   <= w_nx;
          end
        end
        ST_FINISH: begin
          r_state <= ST_IDLE;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_ready <= 1'b1;
        end
        default: begin
          r_state <= ST_IDLE;
          r_wr_en <= 1'b0;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_ready <= 1'b0;
        end
      endcase
    end
  end

  assign cmd_ready = r_ready;
  assign wr_en     = r_wr_en;
  assign wr_row    = r_row;
  assign wr_col    = r_col;
  assign wr_r      = r_rgb.r;
  assign wr_g      = r_rgb.g;
  assign wr_b      = r_rgb.b;
  assign busy      = r_busy;
  assign done      = r_done;

endmodule

// File: tb/tb_vram_writer.sv
// tb/tb_vram_writer.sv - self-checking bench for vram_writer: vector table plus abort, reset and full-screen sequences
module tb_vram_writer;

  logic       vga_clk = 1'b0;
  always #5 vga_clk = ~vga_clk;

  logic       rst_n;
  logic       cmd_valid;
  logic       b_cmd_valid;
  logic       abort;
  logic [9:0] cmd_x0, cmd_x1;
  logic [8:0] cmd_y0, cmd_y1;
  logic [11:0] cmd_color;

  logic       cmd_ready, wr_en, busy, done;
  logic [8:0] wr_row;
  logic [9:0] wr_col;
  logic [2:0] wr_r, wr_g;
  logic [1:0] wr_b;

  logic       b_cmd_ready, b_wr_en, b_busy, b_done;
  logic [8:0] b_wr_row;
  logic [9:0] b_wr_col;
  logic [2:0] b_wr_r, b_wr_g;
  logic [1:0] b_wr_b;

  vram_writer dut (
    .vga_clk(vga_clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_x0(cmd_x0), .cmd_x1(cmd_x1), .cmd_y0(cmd_y0), .cmd_y1(cmd_y1),
    .cmd_color(cmd_color), .abort(abort), .wr_en(wr_en), .wr_row(wr_row),
    .wr_col(wr_col), .wr_r(wr_r), .wr_g(wr_g), .wr_b(wr_b), .busy(busy), .done(done)
  );

  // Small screen so a complete full-screen fill fits in a short run
  vram_writer #(.H_RES(32), .V_RES(24)) dut_small (
    .vga_clk(vga_clk), .rst_n(rst_n), .cmd_valid(b_cmd_valid), .cmd_ready(b_cmd_ready),
    .cmd_x0(cmd_x0), .cmd_x1(cmd_x1), .cmd_y0(cmd_y0), .cmd_y1(cmd_y1),
    .cmd_color(cmd_color), .abort(abort), .wr_en(b_wr_en), .wr_row(b_wr_row),
    .wr_col(b_wr_col), .wr_r(b_wr_r), .wr_g(b_wr_g), .wr_b(b_wr_b), .busy(b_busy), .done(b_done)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic send(input logic [9:0] x0, input logic [9:0] x1, input logic [8:0] y0,
                      input logic [8:0] y1, input logic [11:0] c, input bit to_b);
    int w;
    w = 0;
    @(negedge vga_clk);
    while (!(to_b ? b_cmd_ready : cmd_ready) && w < 50) begin
      @(negedge vga_clk);
      w++;
    end
    chk("cmd_ready_wait", to_b ? b_cmd_ready : cmd_ready, 1);
    cmd_x0 = x0; cmd_x1 = x1; cmd_y0 = y0; cmd_y1 = y1; cmd_color = c;
    if (to_b) b_cmd_valid = 1'b1;
    else      cmd_valid   = 1'b1;
    @(posedge vga_clk);
    #1;
    cmd_valid   = 1'b0;
    b_cmd_valid = 1'b0;
  endtask

  typedef struct {
    logic [9:0]  x0;
    logic [9:0]  x1;
    logic [8:0]  y0;
    logic [8:0]  y1;
    logic [11:0] color;
    int          cnt;
    int          ex1;
    logic [2:0]  r;
    logic [2:0]  g;
    logic [1:0]  b;
  } vec_t;

  localparam int NV = 8;
  vec_t vecs [NV];

  initial begin
    vec_t v;
    int   w, n_wr, n_gap, n_pos;
    logic have_last;
    logic [8:0] l_row;
    logic [9:0] l_col;
    logic [2:0] l_r, l_g;
    logic [1:0] l_b;

    //          x0     x1      y0    y1    color    cnt ex1  r     g     b
    vecs[0] = '{10'd2,   10'd4,    9'd3,   9'd4,   12'hF0F, 6,  4,   3'd7, 3'd0, 2'd3};
    vecs[1] = '{10'd638, 10'd1000, 9'd479, 9'd500, 12'h123, 2,  639, 3'd1, 3'd1, 2'd0};
    vecs[2] = '{10'd10,  10'd5,    9'd0,   9'd0,   12'hFFF, 0,  10,  3'd0, 3'd0, 2'd0};
    vecs[3] = '{10'd100, 10'd100,  9'd200, 9'd200, 12'h8A5, 1,  100, 3'd2, 3'd5, 2'd2};
    vecs[4] = '{10'd0,   10'd3,    9'd10,  9'd5,   12'hFFF, 0,  0,   3'd0, 3'd0, 2'd0};
    vecs[5] = '{10'd700, 10'd1023, 9'd0,   9'd0,   12'hFFF, 0,  700, 3'd0, 3'd0, 2'd0};
    vecs[6] = '{10'd0,   10'd3,    9'd0,   9'd2,   12'h7C3, 12, 3,   3'd1, 3'd6, 2'd1};
    vecs[7] = '{10'd0,   10'd5,    9'd480, 9'd500, 12'hFFF, 0,  0,   3'd0, 3'd0, 2'd0};

    rst_n = 1'b0; cmd_valid = 1'b0; b_cmd_valid = 1'b0; abort = 1'b0;
    cmd_x0 = '0; cmd_x1 = '0; cmd_y0 = '0; cmd_y1 = '0; cmd_color = '0;
    have_last = 1'b0;
    l_row = '0; l_col = '0; l_r = '0; l_g = '0; l_b = '0;

    repeat (2) @(negedge vga_clk);
    chk("rst_wr_en", wr_en, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ready", cmd_ready, 0);
    chk("rst_row", wr_row, 0);
    chk("rst_col", wr_col, 0);
    chk("rst_rgb", {wr_r, wr_g, wr_b}, 0);

    @(posedge vga_clk); #1; rst_n = 1'b1;
    @(negedge vga_clk);
    chk("ready_before_first_clk", cmd_ready, 0);
    @(negedge vga_clk);
    chk("ready_after_first_clk", cmd_ready, 1);

    for (int i = 0; i < NV; i++) begin
      v = vecs[i];
      send(v.x0, v.x1, v.y0, v.y1, v.color, 1'b0);
      w = v.ex1 - int'(v.x0) + 1;
      for (int t = 0; t <= v.cnt; t++) begin
        @(negedge vga_clk);
        chk($sformatf("v%0d_t%0d_busy", i, t), busy, 1);
        chk($sformatf("v%0d_t%0d_wr_en", i, t), wr_en, (t < v.cnt) ? 1 : 0);
        chk($sformatf("v%0d_t%0d_done", i, t), done, (t == v.cnt) ? 1 : 0);
        if (t < v.cnt) begin
          chk($sformatf("v%0d_t%0d_row", i, t), wr_row, int'(v.y0) + t / w);
          chk($sformatf("v%0d_t%0d_col", i, t), wr_col, int'(v.x0) + t % w);
          chk($sformatf("v%0d_t%0d_rgb", i, t), {wr_r, wr_g, wr_b}, {v.r, v.g, v.b});
          l_row = 9'(int'(v.y0) + t / w);
          l_col = 10'(int'(v.x0) + t % w);
          l_r = v.r; l_g = v.g; l_b = v.b;
          have_last = 1'b1;
        end
      end
      @(negedge vga_clk);
      chk($sformatf("v%0d_ready_after", i), cmd_ready, 1);
      chk($sformatf("v%0d_idle_busy", i), busy, 0);
      chk($sformatf("v%0d_idle_done", i), done, 0);
      chk($sformatf("v%0d_idle_wr_en", i), wr_en, 0);
      if (have_last) begin
        chk($sformatf("v%0d_hold_row", i), wr_row, l_row);
        chk($sformatf("v%0d_hold_col", i), wr_col, l_col);
        chk($sformatf("v%0d_hold_rgb", i), {wr_r, wr_g, wr_b}, {l_r, l_g, l_b});
      end
    end

    // Abort while idle and during an empty command has no effect
    abort = 1'b1;
    repeat (3) begin
      @(negedge vga_clk);
      chk("abort_idle_ready", cmd_ready, 1);
      chk("abort_idle_busy", busy, 0);
    end
    send(10'd10, 10'd5, 9'd0, 9'd0, 12'hFFF, 1'b0);
    @(negedge vga_clk);
    chk("abort_empty_done", done, 1);
    chk("abort_empty_wr_en", wr_en, 0);
    @(negedge vga_clk);
    chk("abort_empty_ready", cmd_ready, 1);
    chk("abort_empty_done_off", done, 0);
    abort = 1'b0;

    // Abort after the 5th write of a 10-pixel row
    send(10'd0, 10'd9, 9'd5, 9'd5, 12'hFFF, 1'b0);
    n_wr = 0;
    for (int t = 0; t < 5; t++) begin
      @(negedge vga_clk);
      if (wr_en) n_wr++;
      chk($sformatf("abort_col_t%0d", t), wr_col, t);
    end
    abort = 1'b1;
    @(posedge vga_clk); #1; abort = 1'b0;
    @(negedge vga_clk);
    chk("abort_wr_en_off", wr_en, 0);
    chk("abort_done", done, 1);
    chk("abort_busy", busy, 1);
    n_gap = 0;
    for (int t = 0; t < 4; t++) begin
      @(negedge vga_clk);
      if (wr_en) n_wr++;
      if (done) n_gap++;
    end
    chk("abort_writes", n_wr, 5);
    chk("abort_extra_done", n_gap, 0);
    chk("abort_ready", cmd_ready, 1);
    chk("abort_idle_busy_end", busy, 0);

    // Reset in the middle of a fill
    send(10'd0, 10'd639, 9'd10, 9'd10, 12'h0F0, 1'b0);
    repeat (3) @(negedge vga_clk);
    chk("midfill_wr_en", wr_en, 1);
    rst_n = 1'b0;
    #1;
    chk("rst_async_wr_en", wr_en, 0);
    chk("rst_async_busy", busy, 0);
    chk("rst_async_ready", cmd_ready, 0);
    chk("rst_async_done", done, 0);
    @(posedge vga_clk); #1; rst_n = 1'b1;
    @(negedge vga_clk);
    chk("rst_rel_ready0", cmd_ready, 0);
    chk("rst_rel_done0", done, 0);
    chk("rst_rel_wr_en0", wr_en, 0);
    @(negedge vga_clk);
    chk("rst_rel_ready1", cmd_ready, 1);
    chk("rst_rel_done1", done, 0);

    // Full-screen fill on the 32x24 instance, coordinates clamped from the maximum
    send(10'd1023, 10'd1023, 9'd511, 9'd511, 12'h000, 1'b1);
    @(negedge vga_clk);
    chk("small_oob_done", b_done, 1);
    chk("small_oob_wr_en", b_wr_en, 0);
    send(10'd0, 10'd1023, 9'd0, 9'd511, 12'hF0F, 1'b1);
    n_wr = 0; n_gap = 0; n_pos = 0;
    for (int t = 0; t <= 768; t++) begin
      @(negedge vga_clk);
      if (t < 768) begin
        if (b_wr_en) n_wr++;
        else n_gap++;
        if (b_wr_row != 9'(t / 32) || b_wr_col != 10'(t % 32)) n_pos++;
      end else begin
        chk("full_done", b_done, 1);
        chk("full_wr_en_off", b_wr_en, 0);
      end
    end
    chk("full_count", n_wr, 768);
    chk("full_gaps", n_gap, 0);
    chk("full_positions", n_pos, 0);
    chk("full_last_row", b_wr_row, 23);
    chk("full_last_col", b_wr_col, 31);
    chk("full_rgb", {b_wr_r, b_wr_g, b_wr_b}, {3'd7, 3'd0, 2'd3});
    @(negedge vga_clk);
    chk("full_ready", b_cmd_ready, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
